// File: rtl/gmac_mii_mgmt_slave.sv
// MAC register-access responder exposing the GMII address/data registers and
// running one clause-22 MDIO frame per busy-bit write to the address register.
module gmac_mii_mgmt_slave #(
   parameter int unsigned MDC_HALF_DIV = 10
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mac_request,
   input  logic [13:0] i_mac_addr,
   input  logic        i_mac_rdwn,
   input  logic [31:0] i_mac_wr_data,
   output logic        o_mac_done,
   output logic [31:0] o_mac_rd_data,
   output logic        o_mdc,
   output logic        o_mdio_out,
   output logic        o_mdio_oe,
   input  logic        i_mdio_in
);

   localparam int unsigned DivMax = (MDC_HALF_DIV - 1 > 6) ? MDC_HALF_DIV - 1 : 6;
   localparam int unsigned DivW   = $clog2(DivMax + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(MDC_HALF_DIV - 1);

   localparam logic [13:0] AddrGmiiAddr = 14'h010;
   localparam logic [13:0] AddrGmiiData = 14'h014;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StAck   = 2'd1;
   localparam logic [1:0] StFrame = 2'd2;
   localparam logic [1:0] StFin   = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     data_q, data_d;
   logic [31:0]     rd_q, rd_d;
   logic [DivW-1:0] div_q, div_d;
   logic [6:0]      bit_q, bit_d;
   logic            mdc_q, mdc_d;
   logic            mdio_out_q, mdio_out_d;
   logic            oe_q, oe_d;
   logic [15:0]     shift_q, shift_d;

   logic [63:0] frame_word;
   logic [6:0]  bit_nxt;
   logic [5:0]  bit_idx;
   logic [31:0] reg_rd;
   logic        unused_wr_hi;

   assign unused_wr_hi = ^i_mac_wr_data[31:16];

   // Read frames leave TA and data bits at 0; the line is released there anyway.
   always_comb begin
      frame_word[63:18] = {32'hFFFF_FFFF, 2'b01, ~addr_q[1], addr_q[1],
                           addr_q[15:11], addr_q[10:6]};
      frame_word[17:0]  = addr_q[1] ? {2'b10, data_q} : 18'h0;
   end

   assign bit_nxt = bit_q + 7'd1;
   assign bit_idx = 6'(7'd63 - bit_nxt);

   always_comb begin
      reg_rd = 32'h0;
      if (i_mac_addr == AddrGmiiAddr) begin
         reg_rd = {16'h0, addr_q};
      end else if (i_mac_addr == AddrGmiiData) begin
         reg_rd = {16'h0, data_q};
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rd_d       = rd_q;
      div_d      = div_q;
      bit_d      = bit_q;
      mdc_d      = mdc_q;
      mdio_out_d = mdio_out_q;
      oe_d       = oe_q;
      shift_d    = shift_q;
      case (state_q)
         StIdle: begin
            if (i_mac_request) begin
               state_d = StAck;
               rd_d    = i_mac_rdwn ? reg_rd : 32'h0;
               if (!i_mac_rdwn && i_mac_addr == AddrGmiiAddr) begin
                  addr_d = i_mac_wr_data[15:0];
                  if (i_mac_wr_data[0]) begin
                     state_d    = StFrame;
                     div_d      = '0;
                     bit_d      = 7'd0;
                     mdc_d      = 1'b0;
                     oe_d       = 1'b1;
                     mdio_out_d = 1'b1;
                  end
               end else if (!i_mac_rdwn && i_mac_addr == AddrGmiiData) begin
                  data_d = i_mac_wr_data[15:0];
               end
            end
         end
         StAck: begin
            state_d = StIdle;
         end
         StFrame: begin
            if (div_q == DivLast) begin
               div_d = '0;
               if (!mdc_q) begin
                  mdc_d   = 1'b1;
                  shift_d = {shift_q[14:0], i_mdio_in};
               end else begin
                  mdc_d = 1'b0;
                  if (bit_q == 7'd63) begin
                     state_d    = StFin;
                     oe_d       = 1'b0;
                     mdio_out_d = 1'b0;
                     addr_d[0]  = 1'b0;
                     if (!addr_q[1]) begin
                        data_d = shift_q;
                     end
                  end else begin
                     bit_d      = bit_nxt;
                     mdio_out_d = frame_word[bit_idx];
                     oe_d       = addr_q[1] | (bit_nxt < 7'd46);
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         addr_q     <= 16'h0;
         data_q     <= 16'h0;
         rd_q       <= 32'h0;
         div_q      <= '0;
         bit_q      <= 7'd0;
         mdc_q      <= 1'b0;
         mdio_out_q <= 1'b0;
         oe_q       <= 1'b0;
         shift_q    <= 16'h0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rd_q       <= rd_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         mdc_q      <= mdc_d;
         mdio_out_q <= mdio_out_d;
         oe_q       <= oe_d;
         shift_q    <= shift_d;
      end
   end

   assign o_mac_done    = (state_q == StAck) || (state_q == StFin);
   assign o_mac_rd_data = (state_q == StAck) ? rd_q : 32'h0;
   assign o_mdc         = mdc_q;
   assign o_mdio_out    = mdio_out_q;
   assign o_mdio_oe     = oe_q;

endmodule

// File: tb/tb_gmac_mii_mgmt_slave.sv
// Scoreboard bench for gmac_mii_mgmt_slave: a register/frame reference model
// feeds expected completions and MDIO line states to decoupled monitors.
module tb_gmac_mii_mgmt_slave;

   localparam int N        = 2;
   localparam int FrameCyc = 128 * N;

   logic        i_clk;
   logic        i_rst;
   logic        i_mac_request;
   logic [13:0] i_mac_addr;
   logic        i_mac_rdwn;
   logic [31:0] i_mac_wr_data;
   logic        o_mac_done;
   logic [31:0] o_mac_rd_data;
   logic        o_mdc;
   logic        o_mdio_out;
   logic        o_mdio_oe;
   logic        i_mdio_in;

   gmac_mii_mgmt_slave #(.MDC_HALF_DIV(N)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_mac_request (i_mac_request),
      .i_mac_addr    (i_mac_addr),
      .i_mac_rdwn    (i_mac_rdwn),
      .i_mac_wr_data (i_mac_wr_data),
      .o_mac_done    (o_mac_done),
      .o_mac_rd_data (o_mac_rd_data),
      .o_mdc         (o_mdc),
      .o_mdio_out    (o_mdio_out),
      .o_mdio_oe     (o_mdio_oe),
      .i_mdio_in     (i_mdio_in)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      int          cycle;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [15:0] addr_m      = 16'h0;
   logic [15:0] data_m      = 16'h0;
   logic [15:0] phy_data    = 16'h0;
   bit          frame_active = 1'b0;
   bit          frame_gw     = 1'b0;
   int          frame_start  = 0;
   logic [4:0]  f_pa, f_gr;
   logic [15:0] f_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Expected MDIO value of frame bit k, derived from the clause-22 field layout.
   function automatic logic exp_bit(input int k);
      if (k < 32) return 1'b1;
      if (k == 32) return 1'b0;
      if (k == 33) return 1'b1;
      if (k == 34) return frame_gw ? 1'b0 : 1'b1;
      if (k == 35) return frame_gw ? 1'b1 : 1'b0;
      if (k <= 40) return f_pa[40 - k];
      if (k <= 45) return f_gr[45 - k];
      if (k == 46) return 1'b1;
      if (k == 47) return 1'b0;
      return f_data[63 - k];
   endfunction

   // Completion and MDIO line monitor
   always @(negedge i_clk) begin
      if (!i_rst) begin
         int   off;
         int   k;
         logic emdc, eoe, eout, chk_out;
         exp_t e;
         if (o_mac_done) begin
            if (exp_q.size() == 0) begin
               check("spurious_done", 64'(o_mac_done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.cycle));
               check("rd_data", 64'(o_mac_rd_data), 64'(e.data));
            end
         end else begin
            check("rd_data_idle", 64'(o_mac_rd_data), 64'd0);
         end
         off = cyc - frame_start;
         if (frame_active && off >= 0 && off < FrameCyc) begin
            k       = off / (2 * N);
            emdc    = (off % (2 * N)) >= N;
            eoe     = frame_gw || (k < 46);
            chk_out = eoe;
            eout    = eoe ? exp_bit(k) : 1'b0;
         end else begin
            emdc    = 1'b0;
            eoe     = 1'b0;
            chk_out = 1'b1;
            eout    = 1'b0;
         end
         check("mdio_lines", 64'({o_mdc, o_mdio_oe, chk_out ? o_mdio_out : 1'b0}),
               64'({emdc, eoe, eout}));
      end
   end

   // PHY model: drives read data for bits 48-63, held stable for the whole bit
   initial begin
      i_mdio_in = 1'b1;
      forever begin
         int off;
         int k;
         @(posedge i_clk);
         #1;
         off = cyc - frame_start;
         k   = off / (2 * N);
         if (frame_active && !frame_gw && off >= 0 && off < FrameCyc && k >= 48)
            i_mdio_in = phy_data[63 - k];
         else
            i_mdio_in = 1'b1;
      end
   end

   task automatic issue(input logic rdwn, input logic [13:0] a, input logic [31:0] wd);
      logic [31:0] rv;
      int          t;
      exp_t        e;
      @(posedge i_clk);
      #1;
      i_mac_request = 1'b1;
      i_mac_rdwn    = rdwn;
      i_mac_addr    = a;
      i_mac_wr_data = wd;
      t = cyc;
      rv = (a == 14'h010) ? {16'h0, addr_m} : (a == 14'h014) ? {16'h0, data_m} : 32'h0;
      e.cycle = t + 1;
      e.data  = 32'h0;
      if (rdwn) begin
         e.data = rv;
      end else if (a == 14'h010) begin
         addr_m = wd[15:0];
         if (wd[0]) begin
            f_pa         = wd[15:11];
            f_gr         = wd[10:6];
            frame_gw     = wd[1];
            f_data       = data_m;
            frame_start  = t + 1;
            frame_active = 1'b1;
            e.cycle      = t + 1 + FrameCyc;
            addr_m[0]    = 1'b0;
            if (!wd[1]) data_m = phy_data;
         end
      end else if (a == 14'h014) begin
         data_m = wd[15:0];
      end
      exp_q.push_back(e);
      @(posedge i_clk);
      #1;
      i_mac_request = 1'b0;
      i_mac_wr_data = 32'h0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         @(negedge i_clk);
         #1;
         k++;
      end
      if (exp_q.size() != 0) begin
         check("done_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
   endtask

   task automatic access(input logic rdwn, input logic [13:0] a, input logic [31:0] wd);
      issue(rdwn, a, wd);
      wait_done();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      i_rst         = 1'b1;
      i_mac_request = 1'b0;
      i_mac_rdwn    = 1'b0;
      i_mac_addr    = 14'h0;
      i_mac_wr_data = 32'h0;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_outputs", 64'({o_mac_done, o_mdc, o_mdio_oe, o_mdio_out}), 64'd0);
      check("reset_rd_data", 64'(o_mac_rd_data), 64'd0);
      i_rst = 1'b0;

      // Basic register accesses
      access(1'b0, 14'h014, 32'h0000_ABCD);
      access(1'b1, 14'h014, 32'h0);
      access(1'b1, 14'h010, 32'h0);
      access(1'b1, 14'h020, 32'h0);
      access(1'b0, 14'h010, 32'h0000_0D4E);
      access(1'b1, 14'h010, 32'h0);

      // Write frame, then GB must read back clear
      access(1'b0, 14'h010, 32'h0000_0D4F);
      access(1'b1, 14'h010, 32'h0);

      // Read frame with PHY returning 0x1234
      phy_data = 16'h1234;
      access(1'b0, 14'h010, 32'h0000_004D);
      access(1'b1, 14'h014, 32'h0);

      // Request mid-frame must be ignored
      phy_data = 16'h5A3C;
      issue(1'b0, 14'h010, 32'h0000_0A8D);
      repeat (40) @(posedge i_clk);
      #1;
      i_mac_request = 1'b1;
      i_mac_rdwn    = 1'b1;
      i_mac_addr    = 14'h010;
      @(posedge i_clk);
      #1;
      i_mac_request = 1'b0;
      wait_done();
      access(1'b1, 14'h014, 32'h0);

      // Reset during bit 40 of a frame
      issue(1'b0, 14'h010, 32'h0000_0D4F);
      k = 0;
      while (cyc != frame_start + 40 * 2 * N + 1 && k < 1000) begin
         @(posedge i_clk);
         #1;
         k++;
      end
      i_rst = 1'b1;
      exp_q.delete();
      frame_active = 1'b0;
      addr_m = 16'h0;
      data_m = 16'h0;
      @(posedge i_clk);
      #1;
      check("midrst_lines", 64'({o_mac_done, o_mdc, o_mdio_oe, o_mdio_out}), 64'd0);
      i_rst = 1'b0;
      access(1'b1, 14'h010, 32'h0);
      access(1'b1, 14'h014, 32'h0);
      access(1'b0, 14'h014, 32'h0000_7E01);
      access(1'b1, 14'h014, 32'h0);

      // Randomized accesses
      for (int i = 0; i < 24; i++) begin
         int          op;
         logic [31:0] wd;
         logic [13:0] a;
         op = $urandom_range(0, 5);
         wd = $urandom;
         case (op)
            0: access(1'b0, 14'h014, wd);
            1: access(1'b1, 14'h014, 32'h0);
            2: access(1'b1, 14'h010, 32'h0);
            3: begin
               a = 14'($urandom_range(0, 16383));
               if (a == 14'h010 || a == 14'h014) a = 14'h020;
               access(1'($urandom_range(0, 1)), a, wd);
            end
            4: access(1'b0, 14'h010, wd & 32'hFFFF_FFFE);
            default: begin
               phy_data = 16'($urandom);
               access(1'b0, 14'h010, wd | 32'h1);
            end
         endcase
      end
      access(1'b1, 14'h010, 32'h0);
      access(1'b1, 14'h014, 32'h0);

      repeat (4) @(posedge i_clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
